// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Main control FSM of the multicycle MIPS datapath. Sequences
//             each instruction through FETCH / DECODE / execute / writeback
//             states and emits Moore-style datapath enables. The ALUOp pair
//             {aluOP1, aluOP2} feeds the downstream ALU control decoder.
//  Ports    :
//    clk            in   1  rising-edge clock
//    reset          in   1  asynchronous, active-high reset
//    opcode         in   6  IR[31:26], stable from DECODE to instruction end
//    pcWrite        out  1  unconditional PC load
//    pcWriteCond    out  1  PC load if ALU zero (BEQ)
//    pcWriteCondNe  out  1  PC load if ALU not zero (BNE)
//    iorD           out  1  memory address select: 0=PC, 1=ALUOut
//    memRead        out  1  memory read strobe
//    memWrite       out  1  memory write strobe
//    irWrite        out  1  instruction register load
//    memToReg       out  1  regfile write data: 0=ALUOut, 1=MDR
//    regDst         out  1  regfile destination: 0=rt, 1=rd
//    regWrite       out  1  regfile write enable
//    aluSrcA        out  1  ALU A: 0=PC, 1=A register
//    aluSrcB        out  2  ALU B: 00=B, 01=4, 10=imm, 11=imm<<2
//    pcSource       out  2  PC input: 00=ALU, 01=ALUOut, 10=jump target
//    aluOP1/aluOP2  out  1  ALUOp: 00 add, 01 sub, 10 funct field
//    instrDone      out  1  pulse in the last state of each instruction
//    illegalOp      out  1  pulse in DECODE when the opcode is unknown
//    state          out  4  current state (debug)
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter logic [5:0] OP_R    = 6'b000000,
    parameter logic [5:0] OP_LW   = 6'b100011,
    parameter logic [5:0] OP_SW   = 6'b101011,
    parameter logic [5:0] OP_BEQ  = 6'b000100,
    parameter logic [5:0] OP_BNE  = 6'b000101,
    parameter logic [5:0] OP_J    = 6'b000010,
    parameter logic [5:0] OP_ADDI = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pcWriteCondNe,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic       aluOP1,
    output logic       aluOP2,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    state_t     state_q;
    state_t     state_d;
    logic       isbne_q;
    logic       isbne_d;
    logic       opcode_legal;
    logic [1:0] aluop;

    assign opcode_legal = (opcode == OP_R)   || (opcode == OP_LW)  ||
                          (opcode == OP_SW)  || (opcode == OP_BEQ) ||
                          (opcode == OP_BNE) || (opcode == OP_J)   ||
                          (opcode == OP_ADDI);

    // ------------------------------------------------------------------
    // Next-state logic. isBne is captured in DECODE so BRANCH can pick
    // the zero / not-zero PC condition from state alone.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        isbne_d = isbne_q;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                isbne_d = (opcode == OP_BNE);
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_R) begin
                    state_d = S_EXEC;
                end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
            end
            S_EXEC: begin
                state_d = S_ALUWB;
            end
            S_ADDIEX: begin
                state_d = S_ADDIWB;
            end
            // Terminal states and the unreachable codes 12-15 return to FETCH.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            isbne_q <= 1'b0;
        end else begin
            state_q <= state_d;
            isbne_q <= isbne_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode. Gated by reset so that every enable drops the
    // moment reset rises, even though the state register itself reads
    // FETCH during reset.
    // ------------------------------------------------------------------
    always_comb begin
        pcWrite       = 1'b0;
        pcWriteCond   = 1'b0;
        pcWriteCondNe = 1'b0;
        iorD          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        irWrite       = 1'b0;
        memToReg      = 1'b0;
        regDst        = 1'b0;
        regWrite      = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        pcSource      = 2'b00;
        aluop         = ALUOP_ADD;
        instrDone     = 1'b0;
        illegalOp     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b1;
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    aluSrcB = 2'b01;
                end
                S_DECODE: begin
                    // Branch target precomputed into ALUOut: PC + (imm << 2).
                    aluSrcB   = 2'b11;
                    illegalOp = !opcode_legal;
                end
                S_MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                S_MEMWB: begin
                    regWrite  = 1'b1;
                    memToReg  = 1'b1;
                    instrDone = 1'b1;
                end
                S_MEMWR: begin
                    memWrite  = 1'b1;
                    iorD      = 1'b1;
                    instrDone = 1'b1;
                end
                S_EXEC: begin
                    aluSrcA = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    regWrite  = 1'b1;
                    regDst    = 1'b1;
                    instrDone = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA       = 1'b1;
                    aluop         = ALUOP_SUB;
                    pcSource      = 2'b01;
                    pcWriteCond   = !isbne_q;
                    pcWriteCondNe = isbne_q;
                    instrDone     = 1'b1;
                end
                S_JUMP: begin
                    pcWrite   = 1'b1;
                    pcSource  = 2'b10;
                    instrDone = 1'b1;
                end
                S_ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_ADDIWB: begin
                    regWrite  = 1'b1;
                    instrDone = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign aluOP1 = aluop[1];
    assign aluOP2 = aluop[0];
    assign state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Scoreboard bench for multicycle_control. A driver issues
//             opcodes and queues the per-cycle control word each instruction
//             should produce; a monitor pops one word per cycle and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    localparam logic [5:0] C_OP_R    = 6'b000000;
    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_BNE  = 6'b000101;
    localparam logic [5:0] C_OP_J    = 6'b000010;
    localparam logic [5:0] C_OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcWriteCondNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSource;
        logic       aluOP1;
        logic       aluOP2;
        logic       instrDone;
        logic       illegalOp;
        logic [3:0] state;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite;
    logic       irWrite, memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, pcSource;
    logic       aluOP1, aluOP2, instrDone, illegalOp;
    logic [3:0] state;
    ctl_t       obs;

    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    ctl_t exp_q[$];

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .pcWrite       (pcWrite),
        .pcWriteCond   (pcWriteCond),
        .pcWriteCondNe (pcWriteCondNe),
        .iorD          (iorD),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .irWrite       (irWrite),
        .memToReg      (memToReg),
        .regDst        (regDst),
        .regWrite      (regWrite),
        .aluSrcA       (aluSrcA),
        .aluSrcB       (aluSrcB),
        .pcSource      (pcSource),
        .aluOP1        (aluOP1),
        .aluOP2        (aluOP2),
        .instrDone     (instrDone),
        .illegalOp     (illegalOp),
        .state         (state)
    );

    always #5 clk = ~clk;

    assign obs = {pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite,
                  irWrite, memToReg, regDst, regWrite, aluSrcA, aluSrcB,
                  pcSource, aluOP1, aluOP2, instrDone, illegalOp, state};

    // ------------------------------------------------------------------
    // Reference model: the walk of named steps each instruction class
    // takes, and the control word required in each step.
    // ------------------------------------------------------------------
    function automatic bit is_legal(input logic [5:0] op);
        return op inside {C_OP_R, C_OP_LW, C_OP_SW, C_OP_BEQ, C_OP_BNE, C_OP_J, C_OP_ADDI};
    endfunction

    function automatic int walk_len(input logic [5:0] op);
        case (op)
            C_OP_LW:                     return 5;
            C_OP_SW, C_OP_R, C_OP_ADDI:  return 4;
            C_OP_BEQ, C_OP_BNE, C_OP_J:  return 3;
            default:                     return 2;
        endcase
    endfunction

    // Step k (0-based) of the instruction's walk, as the debug state code.
    function automatic int walk_step(input logic [5:0] op, input int k);
        int third;
        int fourth;
        if (k == 0) return 0;
        if (k == 1) return 1;
        case (op)
            C_OP_LW:   begin third = 2;  fourth = 3;  end
            C_OP_SW:   begin third = 2;  fourth = 5;  end
            C_OP_R:    begin third = 6;  fourth = 7;  end
            C_OP_ADDI: begin third = 10; fourth = 11; end
            C_OP_J:    begin third = 9;  fourth = 0;  end
            default:   begin third = 8;  fourth = 0;  end
        endcase
        if (k == 2) return third;
        if (k == 3) return fourth;
        return 4;
    endfunction

    function automatic ctl_t expect_word(input logic [5:0] op, input int k);
        ctl_t c;
        int   st;
        bit   last;
        c     = '0;
        st    = walk_step(op, k);
        last  = (k == walk_len(op) - 1) && is_legal(op);
        c.state     = 4'(st);
        c.instrDone = last;
        case (st)
            0:  begin c.pcWrite = 1; c.memRead = 1; c.irWrite = 1; c.aluSrcB = 2'b01; end
            1:  begin c.aluSrcB = 2'b11; c.illegalOp = !is_legal(op); end
            2, 10: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            3:  begin c.memRead = 1; c.iorD = 1; end
            4:  begin c.regWrite = 1; c.memToReg = 1; end
            5:  begin c.memWrite = 1; c.iorD = 1; end
            6:  begin c.aluSrcA = 1; c.aluOP1 = 1; end
            7:  begin c.regWrite = 1; c.regDst = 1; end
            8:  begin
                    c.aluSrcA = 1; c.aluOP2 = 1; c.pcSource = 2'b01;
                    c.pcWriteCond   = (op == C_OP_BEQ);
                    c.pcWriteCondNe = (op == C_OP_BNE);
                end
            9:  begin c.pcWrite = 1; c.pcSource = 2'b10; end
            11: begin c.regWrite = 1; end
            default: begin end
        endcase
        return c;
    endfunction

    task automatic check(input string name, input ctl_t got, input ctl_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h (state %0d) required %h (state %0d)",
                     name, $time, got, got.state, want, want.state);
        end
    endtask

    // Issue one instruction; 'steps' below its full length truncates it.
    task automatic issue(input logic [5:0] op, input int steps);
        for (int k = 0; k < steps; k++) exp_q.push_back(expect_word(op, k));
        opcode = op;
        repeat (steps) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0: op = C_OP_R;
            1: op = C_OP_LW;
            2: op = C_OP_SW;
            3: op = C_OP_BEQ;
            4: op = C_OP_BNE;
            5: op = C_OP_J;
            6: op = C_OP_ADDI;
            default: begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    // Monitor: one control word per cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (reset) begin
                    check("reset_outputs", obs, ctl_t'(0));
                end else if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_underflow @%0t: got state %0d with no expected word queued",
                             $time, obs.state);
                end else begin
                    check("cycle_word", obs, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [5:0] op;
        // Reset for three cycles, checked each cycle by the monitor.
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Directed walk through every instruction class.
        issue(C_OP_LW,   walk_len(C_OP_LW));
        issue(C_OP_SW,   walk_len(C_OP_SW));
        issue(C_OP_R,    walk_len(C_OP_R));
        issue(C_OP_BEQ,  walk_len(C_OP_BEQ));
        issue(C_OP_BNE,  walk_len(C_OP_BNE));
        issue(6'b111111, 2);
        issue(C_OP_J,    walk_len(C_OP_J));
        issue(C_OP_ADDI, walk_len(C_OP_ADDI));
        issue(C_OP_BEQ,  walk_len(C_OP_BEQ));

        // Reset asserted while an LW sits in MEMRD.
        issue(C_OP_LW, 3);
        exp_q.push_back(expect_word(C_OP_LW, 3));
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("async_reset_immediate", obs, ctl_t'(0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            op = rand_op();
            issue(op, walk_len(op));
        end

        mon_en = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d words left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
